// File: rtl/div_ext_pkg.sv
// Shared constants for the RV32M divide/remainder extension: func3 encodings,
// controller state encoding and default datapath width.
package div_ext_pkg;

   localparam int DIV_WIDTH = 32;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quot} left, trial-subtract divisor.
// Purely combinational; the borrow lives in the extra top bit of the difference.
module div_step
   import div_ext_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quot_i,
   input  logic [WIDTH-1:0] div_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quot_o
);

   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;

   assign rem_sh = {rem_i, quot_i[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, div_i};

   // rem < div holds between steps, so a kept difference always fits WIDTH bits
   assign rem_o  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
   assign quot_o = {quot_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_ext.sv
// Iterative radix-2 DIV/DIVU/REM/REMU responder on the CPU ext port (func3[2]=1 only).
// Fixed 34-edge latency; define DIV_EARLY_OUT_EN to short-cut b==0, overflow and |a|<|b|.
module div_ext
   import div_ext_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       func3,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] r,
   output logic             done,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] div_q, div_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             sel_rem_q, sel_rem_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] rem_nx, quot_nx;
   logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;
   logic             a_neg, b_neg;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i  (rem_q),
      .quot_i (quot_q),
      .div_i  (div_q),
      .rem_o  (rem_nx),
      .quot_o (quot_nx)
   );

   assign a_neg = ~func3[0] & a[WIDTH-1];
   assign b_neg = ~func3[0] & b[WIDTH-1];
   assign a_abs = a_neg ? -a : a;
   assign b_abs = b_neg ? -b : b;

   // Divide-by-zero must keep the all-ones quotient whatever the operand signs
   assign q_fix = (qneg_q && (div_q != '0)) ? -quot_q : quot_q;
   assign r_fix = rneg_q ? -rem_q : rem_q;

`ifdef DIV_EARLY_OUT_EN
   logic early_ovf;
   assign early_ovf = ~func3[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quot_d    = quot_q;
      div_d     = div_q;
      r_d       = r_q;
      sel_rem_d = sel_rem_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && func3[2]) begin
               div_d     = b_abs;
               quot_d    = a_abs;
               rem_d     = '0;
               sel_rem_d = func3[1];
               qneg_d    = a_neg ^ b_neg;
               rneg_d    = a_neg;
               cnt_d     = '0;
               state_d   = CALC;
`ifdef DIV_EARLY_OUT_EN
               if (b_abs == '0) begin
                  quot_d  = '1;
                  rem_d   = a_abs;
                  state_d = FIX;
               end else if (early_ovf) begin
                  quot_d  = a_abs;
                  rem_d   = '0;
                  state_d = FIX;
               end else if (a_abs < b_abs) begin
                  quot_d  = '0;
                  rem_d   = a_abs;
                  state_d = FIX;
               end
`endif
            end
         end
         CALC: begin
            rem_d  = rem_nx;
            quot_d = quot_nx;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == '1) begin
               state_d = FIX;
            end
         end
         FIX: begin
            r_d     = sel_rem_q ? r_fix : q_fix;
            done_d  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quot_q    <= '0;
         div_q     <= '0;
         r_q       <= '0;
         sel_rem_q <= 1'b0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quot_q    <= quot_d;
         div_q     <= div_d;
         r_q       <= r_d;
         sel_rem_q <= sel_rem_d;
         qneg_q    <= qneg_d;
         rneg_q    <= rneg_d;
         done_q    <= done_d;
      end
   end

   assign r    = r_q;
   assign done = done_q;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_div_ext.sv
// Directed-vector bench for div_ext: quotient/remainder values, latency, busy/done
// handshake, ignored starts and asynchronous reset abort.
module tb_div_ext;
   import div_ext_pkg::*;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  func3 = 3'b000;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic [31:0] r;
   logic        done;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   div_ext dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .func3 (func3),
      .a     (a),
      .b     (b),
      .r     (r),
      .done  (done),
      .busy  (busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op; optionally poke a second start mid-flight or alongside done.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [31:0] exp,
                         input int poke_at, input bit coincide);
      int n       = 0;
      bit seen    = 1'b0;
      bit busy_ok = 1'b1;
      @(negedge clk);
      start = 1'b1; func3 = f; a = aa; b = bb;
      while (!seen && n < 100) begin
         @(posedge clk); #1;
         n++;
         start = 1'b0;
         if (n == poke_at) begin
            start = 1'b1; func3 = F3_DIVU; a = 32'd50; b = 32'd5;
         end
         if (done) seen = 1'b1;
         if (!busy) busy_ok = 1'b0;
      end
      check({tag, "_done"}, 32'(seen), 32'd1);
`ifndef DIV_EARLY_OUT_EN
      check({tag, "_lat"}, 32'(n), 32'd34);
`endif
      check({tag, "_r"}, r, exp);
      check({tag, "_busy"}, 32'(busy_ok), 32'd1);
      if (coincide) begin
         start = 1'b1; func3 = F3_DIVU; a = 32'd1; b = 32'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
      check({tag, "_hold"}, r, exp);
   endtask

   initial begin
      bit any_busy;
      bit any_done;

      #12;
      check("rst_r", r, 32'd0);
      check("rst_done_busy", {30'd0, done, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14, 0, 1'b0);
      run_op("remu_100_7", F3_REMU, 32'd100, 32'd7, 32'd2, 0, 1'b0);
      run_op("div_m7_2",   F3_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 1'b0);
      run_op("rem_m7_2",   F3_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 1'b0);
      run_op("divu_5_0",   F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
      run_op("remu_5_0",   F3_REMU, 32'd5, 32'd0, 32'd5, 0, 1'b0);
      run_op("div_m5_0",   F3_DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0, 1'b1);
      run_op("rem_m5_0",   F3_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0, 1'b0);

      // MUL encoding must be ignored entirely; r keeps -5 from the last op
      @(negedge clk);
      start = 1'b1; func3 = 3'b000; a = 32'd3; b = 32'd4;
      any_busy = 1'b0;
      any_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (busy) any_busy = 1'b1;
         if (done) any_done = 1'b1;
      end
      check("mul_busy", 32'(any_busy), 32'd0);
      check("mul_done", 32'(any_done), 32'd0);
      check("mul_r", r, 32'hFFFF_FFFB);

      run_op("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0);
      run_op("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
      run_op("divu_poke", F3_DIVU, 32'd100, 32'd7, 32'd14, 5, 1'b0);

      // Abort in the middle of CALC, then confirm a clean restart
      @(negedge clk);
      start = 1'b1; func3 = F3_DIVU; a = 32'd1000; b = 32'd3;
      for (int i = 0; i < 11; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      rst = 1'b0;
      #1;
      check("abort_r", r, 32'd0);
      check("abort_done_busy", {30'd0, done, busy}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      run_op("divu_9_3", F3_DIVU, 32'd9, 32'd3, 32'd3, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
